// File: rtl/instr_fetch_ctrl_pkg.sv
// Shared types and constants for the instruction fetch controller.
package instr_fetch_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam int INSTR_BYTES = 4;
  localparam int CNT_W       = 16;
  localparam int ADDR_W      = 32;

endpackage

// File: rtl/instr_fetch_ctrl_fifo.sv
// Prefetch buffer: synchronous FIFO with extra pointer bit for full/empty.
// Storage is not reset; only the pointers are, so the contents are don't-care
// until written.
module instr_fifo #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 2,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              full,
  output logic              empty,
  output logic [AW:0]       count
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW:0]       wr_ptr;
  logic [AW:0]       rd_ptr;
  logic              do_push;
  logic              do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign count   = wr_ptr - rd_ptr;
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign rdata   = mem[rd_ptr[AW-1:0]];

  // Pointer update; reset empties the buffer.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Data storage write.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/instr_fetch_ctrl.sv
// Instruction fetch controller: prefetches up to FIFO_DEPTH instructions with
// a single outstanding memory read, hands them to the decoder and waits for
// every issued instruction to retire before signalling done.
module instr_fetch_ctrl
  import instr_fetch_ctrl_pkg::*;
#(
  parameter int FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [31:0] pc_base,
  input  logic [15:0] instr_count,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_rvalid,
  output logic [31:0] instr,
  output logic        instr_valid,
  input  logic        next_instr,
  input  logic        op_done,
  output logic        busy,
  output logic        done
);

  localparam int          AW       = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FIFO_CAP = (AW+1)'(FIFO_DEPTH);

  state_t             state_q;
  logic [CNT_W-1:0]   count_q;
  logic [ADDR_W-1:0]  pc_base_q;
  logic [CNT_W-1:0]   fetched_q;
  logic [CNT_W-1:0]   issued_q;
  logic [CNT_W-1:0]   retired_q;
  logic               outstanding_q;

  logic               fifo_full;
  logic               fifo_empty;
  logic [AW:0]        fifo_count;
  logic [31:0]        fifo_rdata;
  logic               push;
  logic               xfer;

  // fetched_q counts requests issued, so it is also the index of the next address.
  assign imem_req    = (state_q == RUN) && !outstanding_q && (fetched_q < count_q)
                       && (fifo_count < FIFO_CAP);
  assign imem_addr   = pc_base_q + (32'(fetched_q) * 32'(INSTR_BYTES));
  // A response only counts when we are actually waiting for one.
  assign push        = imem_rvalid && outstanding_q && !fifo_full;
  assign instr_valid = (state_q == RUN) && !fifo_empty;
  assign xfer        = instr_valid && next_instr;
  assign instr       = instr_valid ? fifo_rdata : '0;

  instr_fifo #(
    .DATA_W (32),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (push),
    .pop     (xfer),
    .wdata   (imem_rdata),
    .rdata   (fifo_rdata),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  // Run-control FSM with progress counters and registered busy/done.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      count_q       <= '0;
      pc_base_q     <= '0;
      fetched_q     <= '0;
      issued_q      <= '0;
      retired_q     <= '0;
      outstanding_q <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
    end else begin
      done <= 1'b0;
      // Request and response can never coincide: one needs outstanding low, the other high.
      if (imem_req) begin
        outstanding_q <= 1'b1;
        fetched_q     <= fetched_q + 1'b1;
      end else if (push) begin
        outstanding_q <= 1'b0;
      end
      if (xfer) issued_q <= issued_q + 1'b1;
      if (op_done && (state_q != IDLE)) retired_q <= retired_q + 1'b1;

      case (state_q)
        IDLE: begin
          if (start) begin
            count_q   <= instr_count;
            pc_base_q <= pc_base;
            fetched_q <= '0;
            issued_q  <= '0;
            retired_q <= '0;
            busy      <= 1'b1;
            state_q   <= (instr_count == '0) ? DRAIN : RUN;
          end
        end
        RUN: begin
          if ((fetched_q == count_q) && (issued_q == count_q)) state_q <= DRAIN;
        end
        DRAIN: begin
          if (retired_q == count_q) begin
            state_q <= IDLE;
            busy    <= 1'b0;
            done    <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Directed bench for instr_fetch_ctrl with a memory responder and ALU model.
module tb_instr_fetch_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic [31:0] pc_base;
  logic [15:0] instr_count;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_rvalid;
  logic [31:0] instr;
  logic        instr_valid;
  logic        next_instr;
  logic        op_done;
  logic        busy;
  logic        done;

  int tests  = 0;
  int failed = 0;

  always #5 clk = ~clk;

  instr_fetch_ctrl #(.FIFO_DEPTH(2)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .start       (start),
    .pc_base     (pc_base),
    .instr_count (instr_count),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_rdata  (imem_rdata),
    .imem_rvalid (imem_rvalid),
    .instr       (instr),
    .instr_valid (instr_valid),
    .next_instr  (next_instr),
    .op_done     (op_done),
    .busy        (busy),
    .done        (done)
  );

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return a ^ 32'h5A00_0013;
  endfunction

  // Memory responder / ALU model state.
  int          lat      = 1;
  bit          mem_en   = 1'b1;
  bit          force_rv = 1'b0;
  int          pend     = 0;
  logic [31:0] pend_addr = '0;
  logic [31:0] req_log  [16];
  logic [31:0] xfer_log [16];
  int          req_cnt  = 0;
  int          xfer_cnt = 0;
  int          done_cnt = 0;
  logic [1:0]  alu_sr   = '0;

  // Inputs from the environment change on the falling edge only.
  always @(negedge clk) begin
    bit fire;
    bit xf;
    fire = (pend == 1);
    if (pend > 0) pend--;
    imem_rvalid = fire || force_rv;
    imem_rdata  = fire ? instr_of(pend_addr) : 32'hDEAD_BEEF;
    if (imem_req === 1'b1) begin
      if (req_cnt < 16) req_log[req_cnt] = imem_addr;
      req_cnt++;
      if (mem_en) begin
        pend      = lat;
        pend_addr = imem_addr;
      end
    end
    xf = (instr_valid === 1'b1) && (next_instr === 1'b1);
    if (xf) begin
      if (xfer_cnt < 16) xfer_log[xfer_cnt] = instr;
      xfer_cnt++;
    end
    op_done = alu_sr[1];
    alu_sr  = {alu_sr[0], xf};
    if (done === 1'b1) done_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    req_cnt  = 0;
    xfer_cnt = 0;
    done_cnt = 0;
  endtask

  task automatic wait_done(input string tag, input int max_cyc);
    int n;
    n = 0;
    while (done !== 1'b1 && n < max_cyc) begin
      step(1);
      n++;
    end
    chk({tag, "_done_seen"}, 32'(done), 32'd1);
  endtask

  task automatic launch(input logic [31:0] pc, input logic [15:0] cnt);
    pc_base     = pc;
    instr_count = cnt;
    start       = 1'b1;
    step(1);
    start       = 1'b0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, observed timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n     = 1'b0;
    start       = 1'b0;
    pc_base     = '0;
    instr_count = '0;
    next_instr  = 1'b0;
    op_done     = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata  = '0;
    step(3);
    chk("rst_req",   32'(imem_req),    32'd0);
    chk("rst_addr",  imem_addr,        32'd0);
    chk("rst_instr", instr,            32'd0);
    chk("rst_ivld",  32'(instr_valid), 32'd0);
    chk("rst_busy",  32'(busy),        32'd0);
    chk("rst_done",  32'(done),        32'd0);
    reset_n = 1'b1;
    step(2);

    // Basic three-instruction run.
    clear_logs();
    next_instr = 1'b1;
    launch(32'h0000_0100, 16'd3);
    chk("t1_busy", 32'(busy), 32'd1);
    wait_done("t1", 80);
    step(2);
    chk("t1_reqs",  32'(req_cnt),  32'd3);
    chk("t1_a0",    req_log[0],    32'h0000_0100);
    chk("t1_a1",    req_log[1],    32'h0000_0104);
    chk("t1_a2",    req_log[2],    32'h0000_0108);
    chk("t1_xfers", 32'(xfer_cnt), 32'd3);
    chk("t1_i0",    xfer_log[0],   instr_of(32'h0000_0100));
    chk("t1_i1",    xfer_log[1],   instr_of(32'h0000_0104));
    chk("t1_i2",    xfer_log[2],   instr_of(32'h0000_0108));
    chk("t1_done1", 32'(done_cnt), 32'd1);
    chk("t1_idle",  32'(busy),     32'd0);

    // Zero-length run.
    clear_logs();
    launch(32'h0000_0040, 16'd0);
    chk("t2_busy1", 32'(busy),     32'd1);
    chk("t2_done0", 32'(done),     32'd0);
    chk("t2_noreq", 32'(imem_req), 32'd0);
    step(1);
    chk("t2_busy0", 32'(busy),     32'd0);
    chk("t2_done1", 32'(done),     32'd1);
    step(1);
    chk("t2_done_clr", 32'(done),  32'd0);
    chk("t2_reqs",  32'(req_cnt),  32'd0);

    // Address wrap-around.
    clear_logs();
    launch(32'hFFFF_FFFC, 16'd2);
    wait_done("t3", 80);
    step(2);
    chk("t3_a0", req_log[0],  32'hFFFF_FFFC);
    chk("t3_a1", req_log[1],  32'h0000_0000);
    chk("t3_i1", xfer_log[1], instr_of(32'h0000_0000));

    // Decoder stall fills the buffer.
    clear_logs();
    next_instr = 1'b0;
    launch(32'h0000_2000, 16'd4);
    step(5);
    chk("t4_ivld_a",  32'(instr_valid), 32'd1);
    chk("t4_instr_a", instr,            instr_of(32'h0000_2000));
    step(5);
    chk("t4_reqs",    32'(req_cnt),     32'd2);
    chk("t4_stall",   32'(imem_req),    32'd0);
    chk("t4_instr_b", instr,            instr_of(32'h0000_2000));
    next_instr = 1'b1;
    wait_done("t4", 120);
    step(2);
    chk("t4_reqs_all", 32'(req_cnt),  32'd4);
    chk("t4_xfers",    32'(xfer_cnt), 32'd4);
    chk("t4_i0",       xfer_log[0],   instr_of(32'h0000_2000));
    chk("t4_i2",       xfer_log[2],   instr_of(32'h0000_2008));
    chk("t4_i3",       xfer_log[3],   instr_of(32'h0000_200C));

    // Start while busy is ignored.
    clear_logs();
    launch(32'h0000_0300, 16'd2);
    step(1);
    launch(32'h0000_0900, 16'd5);
    chk("t5_busy", 32'(busy), 32'd1);
    wait_done("t5", 80);
    step(2);
    chk("t5_reqs",  32'(req_cnt),  32'd2);
    chk("t5_a0",    req_log[0],    32'h0000_0300);
    chk("t5_a1",    req_log[1],    32'h0000_0304);
    chk("t5_xfers", 32'(xfer_cnt), 32'd2);
    chk("t5_done1", 32'(done_cnt), 32'd1);

    // Reset with a request outstanding, then a stray late response.
    clear_logs();
    mem_en     = 1'b0;
    next_instr = 1'b0;
    launch(32'h0000_0400, 16'd3);
    step(1);
    chk("t6_outst", 32'(imem_req), 32'd0);
    chk("t6_req1",  32'(req_cnt),  32'd1);
    reset_n = 1'b0;
    #1;
    chk("t6_req",   32'(imem_req),    32'd0);
    chk("t6_addr",  imem_addr,        32'd0);
    chk("t6_instr", instr,            32'd0);
    chk("t6_ivld",  32'(instr_valid), 32'd0);
    chk("t6_busy",  32'(busy),        32'd0);
    chk("t6_done",  32'(done),        32'd0);
    step(2);
    reset_n = 1'b1;
    step(1);
    force_rv = 1'b1;
    step(1);
    force_rv = 1'b0;
    step(1);
    chk("t6_idle", 32'(busy), 32'd0);
    clear_logs();
    mem_en     = 1'b1;
    next_instr = 1'b1;
    launch(32'h0000_0500, 16'd1);
    wait_done("t6", 80);
    step(2);
    chk("t6_xfers", 32'(xfer_cnt), 32'd1);
    chk("t6_i0",    xfer_log[0],   instr_of(32'h0000_0500));
    chk("t6_reqs",  32'(req_cnt),  32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
